// File: rtl/intra_4x4_mode_sched.sv
// 4x4 luma intra scheduler: walks one MB in z-order, picks V/H/DC by minimum SAD,
// streams the residual out and folds the reconstructed edges back into the line buffers.
module intra_4x4_mode_sched #(
    parameter int         FRAME_W = 352,
    parameter int         FRAME_H = 288,
    parameter int         PIX_W   = 8,
    parameter logic [2:0] MODE_EN = 3'b111
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                mb_valid_i,
    output logic                                mb_ready_o,
    input  logic [5:0]                          mb_x_i,
    input  logic [5:0]                          mb_y_i,
    input  logic [15:0][15:0][PIX_W-1:0]        mb_pix_i,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output logic [3:0][3:0][PIX_W:0]            res_o,
    output logic [1:0]                          res_mode_o,
    output logic [3:0]                          blk_idx_o,
    output logic [9:0]                          topleft_x_o,
    output logic [9:0]                          topleft_y_o,
    input  logic                                recon_valid_i,
    input  logic [3:0][3:0][PIX_W-1:0]          recon_i,
    output logic                                mb_done_o
);
    localparam int SW = PIX_W + 4;
    localparam int XW = $clog2(FRAME_W);
    localparam int YW = $clog2(FRAME_H);
    typedef logic [PIX_W-1:0] pix_t;
    typedef enum logic [3:0] {IDLE, LOAD, NBR, SAD, DECIDE, RES_OUT, WAIT_REC, UPDATE, DONE} state_t;

    state_t state, state_nx;
    logic [5:0] mbx, mby;
    logic [15:0][15:0][PIX_W-1:0] pix;
    logic [3:0] blk;
    logic [1:0] srow;
    pix_t top_buf [FRAME_W];
    pix_t left_buf [FRAME_H];
    logic [3:0][PIX_W-1:0] nbr_t, nbr_l;
    logic top_av, left_av;
    logic [SW-1:0] sad_v, sad_h, sad_dc;
    logic [3:0][3:0][PIX_W-1:0] rec;
    logic [1:0] mode;
    logic [3:0][3:0][PIX_W:0] res;

    logic [3:0] x_off, y_off;
    logic [9:0] tl_x, tl_y;
    logic [3:0][XW-1:0] t_idx;
    logic [3:0][YW-1:0] l_idx;
    logic [3:0][3:0][PIX_W-1:0] blk_pix;
    logic [PIX_W+1:0] sum_t, sum_l, sum_t2, sum_l2;
    logic [PIX_W+2:0] sum_a;
    pix_t dc, pred;
    logic [SW-1:0] rs_v, rs_h, rs_dc, best;
    logic [1:0] mode_nx;
    logic [3:0][3:0][PIX_W:0] res_nx;

    function automatic pix_t absd(input pix_t a, input pix_t b);
        return (a > b) ? a - b : b - a;
    endfunction

    assign x_off = {blk[2], blk[0], 2'b00};
    assign y_off = {blk[3], blk[1], 2'b00};
    assign tl_x  = {mbx, 4'b0000} + {6'd0, x_off};
    assign tl_y  = {mby, 4'b0000} + {6'd0, y_off};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            t_idx[i] = XW'(tl_x + 10'(i));
            l_idx[i] = YW'(tl_y + 10'(i));
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                blk_pix[r][c] = pix[y_off + 4'(r)][x_off + 4'(c)];
    end

    // DC predictor from the latched neighbours, rounding as in H.264
    always_comb begin
        sum_t = '0;
        sum_l = '0;
        for (int i = 0; i < 4; i++) begin
            sum_t = sum_t + (PIX_W+2)'(nbr_t[i]);
            sum_l = sum_l + (PIX_W+2)'(nbr_l[i]);
        end
        sum_a  = (PIX_W+3)'(sum_t) + (PIX_W+3)'(sum_l) + (PIX_W+3)'(4);
        sum_t2 = sum_t + (PIX_W+2)'(2);
        sum_l2 = sum_l + (PIX_W+2)'(2);
        if (top_av && left_av) dc = sum_a[PIX_W+2:3];
        else if (top_av)       dc = sum_t2[PIX_W+1:2];
        else if (left_av)      dc = sum_l2[PIX_W+1:2];
        else                   dc = pix_t'(1) << (PIX_W-1);
    end

    always_comb begin
        rs_v  = '0;
        rs_h  = '0;
        rs_dc = '0;
        for (int c = 0; c < 4; c++) begin
            rs_v  = rs_v  + SW'(absd(blk_pix[srow][c], nbr_t[c]));
            rs_h  = rs_h  + SW'(absd(blk_pix[srow][c], nbr_l[srow]));
            rs_dc = rs_dc + SW'(absd(blk_pix[srow][c], dc));
        end
    end

    // Later candidates win only with <=, so ties settle on the lower mode number
    always_comb begin
        mode_nx = 2'd2;
        best    = sad_dc;
        if (MODE_EN[1] && left_av && sad_h <= best) begin
            mode_nx = 2'd1;
            best    = sad_h;
        end
        if (MODE_EN[0] && top_av && sad_v <= best) mode_nx = 2'd0;
        pred = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                case (mode_nx)
                    2'd0:    pred = nbr_t[c];
                    2'd1:    pred = nbr_l[r];
                    default: pred = dc;
                endcase
                res_nx[r][c] = {1'b0, blk_pix[r][c]} - {1'b0, pred};
            end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (mb_valid_i) state_nx = LOAD;
            LOAD:     state_nx = NBR;
            NBR:      state_nx = SAD;
            SAD:      if (srow == 2'd3) state_nx = DECIDE;
            DECIDE:   state_nx = RES_OUT;
            RES_OUT:  if (res_ready_i) state_nx = WAIT_REC;
            WAIT_REC: if (recon_valid_i) state_nx = UPDATE;
            UPDATE:   state_nx = (blk == 4'd15) ? DONE : NBR;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mbx <= '0; mby <= '0; pix <= '0; blk <= '0; srow <= '0;
            nbr_t <= '0; nbr_l <= '0; top_av <= 1'b0; left_av <= 1'b0;
            sad_v <= '0; sad_h <= '0; sad_dc <= '0;
            rec <= '0; mode <= '0; res <= '0;
            for (int i = 0; i < FRAME_W; i++) top_buf[i] <= '0;
            for (int i = 0; i < FRAME_H; i++) left_buf[i] <= '0;
        end else begin
            case (state)
                IDLE: if (mb_valid_i) begin
                    mbx <= mb_x_i;
                    mby <= mb_y_i;
                    pix <= mb_pix_i;
                end
                LOAD: blk <= '0;
                NBR: begin
                    for (int i = 0; i < 4; i++) begin
                        nbr_t[i] <= top_buf[t_idx[i]];
                        nbr_l[i] <= left_buf[l_idx[i]];
                    end
                    top_av  <= (tl_y != '0);
                    left_av <= (tl_x != '0);
                    sad_v   <= '0;
                    sad_h   <= '0;
                    sad_dc  <= '0;
                    srow    <= '0;
                end
                SAD: begin
                    sad_v  <= sad_v + rs_v;
                    sad_h  <= sad_h + rs_h;
                    sad_dc <= sad_dc + rs_dc;
                    srow   <= srow + 2'd1;
                end
                DECIDE: begin
                    mode <= mode_nx;
                    res  <= res_nx;
                end
                WAIT_REC: if (recon_valid_i) rec <= recon_i;
                UPDATE: begin
                    for (int i = 0; i < 4; i++) begin
                        top_buf[t_idx[i]]  <= rec[3][i];
                        left_buf[l_idx[i]] <= rec[i][3];
                    end
                    if (blk != 4'd15) blk <= blk + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign mb_ready_o  = (state == IDLE);
    assign res_valid_o = (state == RES_OUT);
    assign mb_done_o   = (state == DONE);
    assign res_o       = res;
    assign res_mode_o  = mode;
    assign blk_idx_o   = blk;
    assign topleft_x_o = tl_x;
    assign topleft_y_o = tl_y;
endmodule

// File: tb/tb_intra_4x4_mode_sched.sv
// Directed bench: two schedulers (all modes / mode mask 000) driven in lockstep.
module tb_intra_4x4_mode_sched;
    typedef logic [3:0][3:0][8:0] res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mb_valid = 1'b0, res_ready = 1'b0, recon_valid = 1'b0;
    logic [5:0] mb_x = '0, mb_y = '0;
    logic [15:0][15:0][7:0] mb_pix = '0;
    logic [3:0][3:0][7:0] recon = '0;

    logic mb_ready, res_valid, mb_done, mb_ready0, res_valid0, mb_done0;
    res_t res, res0;
    logic [1:0] res_mode, res_mode0;
    logic [3:0] blk_idx, blk_idx0;
    logic [9:0] topleft_x, topleft_y, topleft_x0, topleft_y0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [15:0][15:0][7:0] cur_pix;
    logic rec_orig = 1'b0;
    logic [7:0] rec_val = '0;

    always #5 clk = ~clk;
    always @(posedge clk) if (mb_done === 1'b1) done_cnt++;

    intra_4x4_mode_sched u_dut (
        .clk(clk), .rst(rst), .mb_valid_i(mb_valid), .mb_ready_o(mb_ready),
        .mb_x_i(mb_x), .mb_y_i(mb_y), .mb_pix_i(mb_pix),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_o(res),
        .res_mode_o(res_mode), .blk_idx_o(blk_idx),
        .topleft_x_o(topleft_x), .topleft_y_o(topleft_y),
        .recon_valid_i(recon_valid), .recon_i(recon), .mb_done_o(mb_done)
    );

    intra_4x4_mode_sched #(.MODE_EN(3'b000)) u_dut0 (
        .clk(clk), .rst(rst), .mb_valid_i(mb_valid), .mb_ready_o(mb_ready0),
        .mb_x_i(mb_x), .mb_y_i(mb_y), .mb_pix_i(mb_pix),
        .res_valid_o(res_valid0), .res_ready_i(res_ready), .res_o(res0),
        .res_mode_o(res_mode0), .blk_idx_o(blk_idx0),
        .topleft_x_o(topleft_x0), .topleft_y_o(topleft_y0),
        .recon_valid_i(recon_valid), .recon_i(recon), .mb_done_o(mb_done0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input res_t obs, input res_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input res_t obs, input int v);
        res_t e;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) e[r][c] = 9'(v);
        chk_blk(tag, obs, e);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) cur_pix[r][c] = v;
    endtask

    task automatic mb_start(input logic [5:0] x, input logic [5:0] y);
        int n = 0;
        while (mb_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("mb_ready_wait", 32'(mb_ready), 1);
        mb_x = x; mb_y = y; mb_pix = cur_pix; mb_valid = 1'b1;
        @(negedge clk);
        mb_valid = 1'b0;
    endtask

    // Wait for one residual, capture it, accept it and return the reconstruction.
    task automatic do_blk(input int b, output logic [1:0] m, output logic [1:0] m0,
                          output res_t r, output logic [9:0] tx, output logic [9:0] ty);
        int n = 0;
        int xo, yo;
        while (res_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("res_valid_wait", 32'(res_valid), 1);
        chk("blk_idx", 32'(blk_idx), 32'(b));
        m = res_mode; m0 = res_mode0; r = res; tx = topleft_x; ty = topleft_y;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        xo = ((b >> 2) & 1) * 8 + (b & 1) * 4;
        yo = ((b >> 3) & 1) * 8 + ((b >> 1) & 1) * 4;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                recon[rr][cc] = rec_orig ? cur_pix[yo+rr][xo+cc] : rec_val;
        recon_valid = 1'b1;
        @(negedge clk);
        recon_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0] m, m0;
        res_t r, first;
        logic [9:0] tx, ty;
        int xo, yo, e;

        // reset values
        @(negedge clk);
        chk("rst_mb_ready", 32'(mb_ready), 1);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_mb_done", 32'(mb_done), 0);
        chk("rst_blk_idx", 32'(blk_idx), 0);
        chk_res("rst_res", res, 0);
        rst = 1'b1;
        @(negedge clk);

        // MB(0,0) flat 100; first block held off for 5 cycles with stray recon
        fill_const(8'd100); rec_orig = 1'b0; rec_val = 8'd100;
        mb_start(6'd0, 6'd0);
        for (int n = 0; n < 40 && res_valid !== 1'b1; n++) @(negedge clk);
        first = res;
        for (int k = 0; k < 5; k++) begin
            recon = '0; recon_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_blk", 32'(blk_idx), 0);
            chk_blk("hold_res", res, first);
        end
        recon_valid = 1'b0;
        do_blk(0, m, m0, r, tx, ty);
        chk("t1_blk0_mode", 32'(m), 2);
        chk_res("t1_blk0_res", r, -28);
        do_blk(1, m, m0, r, tx, ty);
        chk("t1_blk1_mode", 32'(m), 1);
        chk_res("t1_blk1_res", r, 0);
        chk("t1_blk1_x", 32'(tx), 4);
        for (int b = 2; b < 16; b++) do_blk(b, m, m0, r, tx, ty);

        // vertical stripes, recon = original; masked DUT must always pick DC
        for (int rr = 0; rr < 16; rr++)
            for (int cc = 0; cc < 16; cc++) cur_pix[rr][cc] = cc[0] ? 8'd200 : 8'd0;
        rec_orig = 1'b1;
        mb_start(6'd0, 6'd0);
        for (int b = 0; b < 16; b++) begin
            do_blk(b, m, m0, r, tx, ty);
            xo = ((b >> 2) & 1) * 8 + (b & 1) * 4;
            yo = ((b >> 3) & 1) * 8 + ((b >> 1) & 1) * 4;
            e = (yo != 0) ? 0 : ((xo == 0) ? 2 : 1);
            chk("t3_mode", 32'(m), 32'(e));
            chk("t3_mode_masked", 32'(m0), 2);
        end

        // MB(0,1) recon 200, MB(1,0) recon 50, then MB(1,1) orig 50
        fill_const(8'd50); rec_orig = 1'b0;
        rec_val = 8'd200;
        mb_start(6'd0, 6'd1);
        for (int b = 0; b < 16; b++) do_blk(b, m, m0, r, tx, ty);
        rec_val = 8'd50;
        mb_start(6'd1, 6'd0);
        for (int b = 0; b < 16; b++) do_blk(b, m, m0, r, tx, ty);
        mb_start(6'd1, 6'd1);
        do_blk(0, m, m0, r, tx, ty);
        chk("t4_mode", 32'(m), 0);
        chk_res("t4_res", r, 0);
        chk("t4_x", 32'(tx), 16);
        chk("t4_y", 32'(ty), 16);
        for (int b = 1; b < 16; b++) do_blk(b, m, m0, r, tx, ty);

        // reset lands while block 5 is in its SAD rows
        fill_const(8'd100); rec_val = 8'd100;
        mb_start(6'd0, 6'd0);
        for (int b = 0; b < 5; b++) do_blk(b, m, m0, r, tx, ty);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t5_mb_ready", 32'(mb_ready), 1);
        chk("t5_res_valid", 32'(res_valid), 0);
        chk("t5_mode", 32'(res_mode), 0);
        chk("t5_blk", 32'(blk_idx), 0);
        chk("t5_x", 32'(topleft_x), 0);
        chk_res("t5_res", res, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // orig 0 against recon 255: full-scale SAD, single done pulse
        fill_const(8'd0); rec_val = 8'd255;
        done_cnt = 0;
        mb_start(6'd0, 6'd0);
        for (int b = 0; b < 16; b++) begin
            do_blk(b, m, m0, r, tx, ty);
            xo = ((b >> 2) & 1) * 8 + (b & 1) * 4;
            yo = ((b >> 3) & 1) * 8 + ((b >> 1) & 1) * 4;
            e = (yo != 0) ? 0 : ((xo == 0) ? 2 : 1);
            chk("t6_mode", 32'(m), 32'(e));
            chk_res("t6_res", r, (b == 0) ? -128 : -255);
        end
        repeat (5) @(negedge clk);
        chk("t6_done_cnt", 32'(done_cnt), 1);
        chk("t6_idle", 32'(mb_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
